// File: rtl/audio_osc_pkg.sv
// Shared types and default widths for the audio oscillator.
package audio_osc_pkg;

    typedef enum logic [1:0] {
        WAVE_SQUARE   = 2'd0,
        WAVE_SAW      = 2'd1,
        WAVE_TRIANGLE = 2'd2,
        WAVE_PULSE    = 2'd3
    } wave_mode_e;

    localparam int ACC_W_DEF  = 19;
    localparam int FREQ_W_DEF = 16;
    localparam int PH_W_DEF   = 8;
    localparam int OUT_W_DEF  = 8;

endpackage

// File: rtl/audio_phase_acc.sv
// Phase accumulator with enable/hard-sync gating; emits a one-cycle tick on each wrap.
module audio_phase_acc
    import audio_osc_pkg::*;
#(
    parameter int ACC_W  = ACC_W_DEF,
    parameter int FREQ_W = FREQ_W_DEF
) (
    input  logic              clk_i,
    input  logic              rstn_i,
    input  logic              en_i,
    input  logic              sync_i,
    input  logic [FREQ_W-1:0] freq_i,
    output logic              tick
);

    logic [ACC_W-1:0] acc_ff;
    logic             msb_dly_ff;

    // NOTE: state registers use non-blocking assignments so every flop samples
    // the pre-edge value of the others, independent of statement order.
    always_ff @(posedge clk_i or negedge rstn_i) begin
        if (!rstn_i) begin
            acc_ff     <= '0;
            msb_dly_ff <= 1'b0;
        end else if (sync_i) begin
            acc_ff     <= '0;
            msb_dly_ff <= 1'b0;
        end else begin
            if (en_i) begin
                acc_ff <= acc_ff + ACC_W'(freq_i);
            end
            msb_dly_ff <= acc_ff[ACC_W-1];
        end
    end

    // A falling MSB marks the accumulator wrapping past 2^ACC_W.
    assign tick = msb_dly_ff & ~acc_ff[ACC_W-1];

endmodule

// File: rtl/audio_osc.sv
// Oscillator top: waveform phase counter, waveform mapping and registered sample output.
module audio_osc
    import audio_osc_pkg::*;
#(
    parameter int ACC_W  = ACC_W_DEF,
    parameter int FREQ_W = FREQ_W_DEF,
    parameter int PH_W   = PH_W_DEF,
    parameter int OUT_W  = OUT_W_DEF
) (
    input  logic              clk_i,
    input  logic              rstn_i,
    input  logic              en_i,
    input  logic              sync_i,
    input  logic [FREQ_W-1:0] freq_i,
    input  logic [1:0]        mode_i,
    input  logic [OUT_W-1:0]  duty_i,
    output logic [OUT_W-1:0]  sample_data_o,
    output logic              sample_valid_o
);

    if (PH_W < OUT_W || PH_W < 2 || FREQ_W > ACC_W) begin : g_param_check
        $error("audio_osc: need PH_W >= OUT_W, PH_W >= 2 and FREQ_W <= ACC_W");
    end

    logic             tick;
    logic [PH_W-1:0]  phase_ff;
    logic             tick_dly_ff;
    logic [OUT_W-1:0] top;
    logic [OUT_W-1:0] tri_field;
    logic [OUT_W-1:0] wave;
    wave_mode_e       mode;

    audio_phase_acc #(
        .ACC_W  (ACC_W),
        .FREQ_W (FREQ_W)
    ) u_phase_acc (
        .clk_i  (clk_i),
        .rstn_i (rstn_i),
        .en_i   (en_i),
        .sync_i (sync_i),
        .freq_i (freq_i),
        .tick   (tick)
    );

    always_ff @(posedge clk_i or negedge rstn_i) begin
        if (!rstn_i) begin
            phase_ff <= '0;
        end else if (sync_i) begin
            phase_ff <= '0;
        end else if (tick) begin
            phase_ff <= phase_ff + 1'b1;
        end
    end

    assign mode = wave_mode_e'(mode_i);
    assign top  = phase_ff[PH_W-1 -: OUT_W];

    // Triangle half-period field, left-aligned and zero-padded when the
    // phase below the MSB is narrower than the sample.
    assign tri_field = OUT_W'({phase_ff[PH_W-2:0], {OUT_W{1'b0}}} >> (PH_W - 1));

    // NOTE: the default assignment ahead of the case keeps this block purely
    // combinational; without it an uncovered path would infer a latch.
    always_comb begin
        wave = '0;
        case (mode)
            WAVE_SQUARE:   wave = {OUT_W{phase_ff[PH_W-1]}};
            WAVE_SAW:      wave = top;
            WAVE_TRIANGLE: wave = phase_ff[PH_W-1] ? ~tri_field : tri_field;
            WAVE_PULSE:    wave = (top < duty_i) ? '1 : '0;
            default:       wave = '0;
        endcase
    end

    // A tick coinciding with sync produces no strobe: the phase it would
    // have shown is overwritten by the restart.
    always_ff @(posedge clk_i or negedge rstn_i) begin
        if (!rstn_i) begin
            sample_data_o  <= '0;
            tick_dly_ff    <= 1'b0;
            sample_valid_o <= 1'b0;
        end else begin
            sample_data_o  <= wave;
            tick_dly_ff    <= tick & ~sync_i;
            sample_valid_o <= tick_dly_ff;
        end
    end

endmodule

// File: tb/tb_audio_osc.sv
// Scoreboard bench for audio_osc: an arithmetic reference model queues expected samples, a monitor compares.
module tb_audio_osc;
    import audio_osc_pkg::*;

    localparam int  ACC_W  = 19;
    localparam int  FREQ_W = 16;
    localparam int  PH_W   = 8;
    localparam int  OUT_W  = 8;
    localparam longint ACC_MOD = 64'd1 << ACC_W;

    logic              clk_i = 1'b0;
    logic              rstn_i;
    logic              en_i;
    logic              sync_i;
    logic [FREQ_W-1:0] freq_i;
    logic [1:0]        mode_i;
    logic [OUT_W-1:0]  duty_i;
    logic [OUT_W-1:0]  sample_data_o;
    logic              sample_valid_o;

    audio_osc #(
        .ACC_W  (ACC_W),
        .FREQ_W (FREQ_W),
        .PH_W   (PH_W),
        .OUT_W  (OUT_W)
    ) dut (
        .clk_i          (clk_i),
        .rstn_i         (rstn_i),
        .en_i           (en_i),
        .sync_i         (sync_i),
        .freq_i         (freq_i),
        .mode_i         (mode_i),
        .duty_i         (duty_i),
        .sample_data_o  (sample_data_o),
        .sample_valid_o (sample_valid_o)
    );

    always #5 clk_i = ~clk_i;

    typedef struct {
        int cyc;
        int data;
    } exp_t;

    exp_t   data_q[$];
    exp_t   strobe_q[$];
    int     checks = 0;
    int     errors = 0;
    int     cyc    = 0;

    // Reference model: accumulator as a plain integer, wraps counted arithmetically.
    longint acc_m;
    bit     wrap_pend;
    bit     strobe_pend;
    int     phase_m;

    task automatic check(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s at cycle %0d: got %0h, expected %0h", name, cyc, act, exp);
        end
    endtask

    function automatic int wave_ref(input int ph, input int mode, input int duty);
        case (mode)
            0:       return (ph < 128) ? 0 : 255;
            1:       return ph;
            2:       return (ph < 128) ? ph * 2 : 255 - (ph - 128) * 2;
            default: return (ph < duty) ? 255 : 0;
        endcase
    endfunction

    always @(posedge clk_i) cyc <= cyc + 1;

    // Monitor: compares the DUT against whatever the model queued for this cycle.
    exp_t mon_e;
    bit   mon_exp_v;
    always @(negedge clk_i) begin
        if (rstn_i) begin
            while (data_q.size() > 0 && data_q[0].cyc < cyc) begin
                check("data_order", data_q[0].cyc, cyc);
                void'(data_q.pop_front());
            end
            if (data_q.size() > 0 && data_q[0].cyc == cyc) begin
                mon_e = data_q.pop_front();
                check("sample_data", int'(sample_data_o), mon_e.data);
            end
            while (strobe_q.size() > 0 && strobe_q[0].cyc < cyc) begin
                check("strobe_order", strobe_q[0].cyc, cyc);
                void'(strobe_q.pop_front());
            end
            mon_exp_v = (strobe_q.size() > 0 && strobe_q[0].cyc == cyc);
            check("sample_valid", int'(sample_valid_o), int'(mon_exp_v));
            if (mon_exp_v) begin
                mon_e = strobe_q.pop_front();
                check("strobe_data", int'(sample_data_o), mon_e.data);
            end
        end
    end

    // One clock of stimulus: queue expectations, advance the model, wait for the edge.
    task automatic step();
        exp_t   e;
        bit     tick;
        longint sum;
        e.cyc  = cyc + 1;
        e.data = wave_ref(phase_m, int'(mode_i), int'(duty_i));
        if (strobe_pend) strobe_q.push_back(e);
        data_q.push_back(e);
        tick        = wrap_pend;
        strobe_pend = tick && !sync_i;
        if (sync_i) begin
            acc_m     = 0;
            phase_m   = 0;
            wrap_pend = 1'b0;
        end else begin
            if (tick) phase_m = (phase_m + 1) % 256;
            if (en_i) begin
                sum       = acc_m + longint'(freq_i);
                wrap_pend = (sum >= ACC_MOD);
                acc_m     = sum % ACC_MOD;
            end else begin
                wrap_pend = 1'b0;
            end
        end
        @(posedge clk_i);
        #1;
    endtask

    task automatic run(input int n);
        repeat (n) step();
    endtask

    task automatic model_clear();
        data_q.delete();
        strobe_q.delete();
        acc_m       = 0;
        wrap_pend   = 1'b0;
        strobe_pend = 1'b0;
        phase_m     = 0;
    endtask

    task automatic do_reset(input int hold);
        rstn_i = 1'b0;
        #1;
        check("reset_data_now", int'(sample_data_o), 0);
        check("reset_valid_now", int'(sample_valid_o), 0);
        model_clear();
        repeat (hold) begin
            @(posedge clk_i);
            #1;
            check("reset_data_hold", int'(sample_data_o), 0);
            check("reset_valid_hold", int'(sample_valid_o), 0);
        end
        rstn_i = 1'b1;
    endtask

    // Advance to a chosen phase, optionally on a tick cycle, then pulse sync.
    task automatic sync_at(input int ph, input bit on_tick);
        int budget = 6000;
        while (!(phase_m == ph && wrap_pend == on_tick) && budget > 0) begin
            step();
            budget--;
        end
        check("sync_target_reached", int'(budget > 0), 1);
        sync_i = 1'b1;
        step();
        sync_i = 1'b0;
        run(40);
    endtask

    initial begin
        #3ms;
        $display("FAIL watchdog: simulation did not finish, errors=%0d", errors);
        $fatal(1, "watchdog");
    end

    initial begin
        rstn_i = 1'b0;
        en_i   = 1'b1;
        sync_i = 1'b0;
        freq_i = 16'h8000;
        mode_i = 2'(WAVE_SAW);
        duty_i = 8'h00;
        model_clear();
        @(posedge clk_i);
        #1;
        do_reset(20);

        run(4200);
        mode_i = 2'(WAVE_SQUARE);
        run(4200);
        mode_i = 2'(WAVE_TRIANGLE);
        run(4200);

        mode_i = 2'(WAVE_PULSE);
        duty_i = 8'h40;
        run(4100);
        duty_i = 8'h00;
        run(300);
        duty_i = 8'h80;
        run(2000);

        mode_i = 2'(WAVE_SAW);
        sync_at(8'h5A, 1'b0);
        sync_at(8'h5A, 1'b1);

        run(7);
        en_i = 1'b0;
        run(100);
        en_i = 1'b1;
        run(200);
        freq_i = 16'h0000;
        run(200);
        freq_i = 16'h8000;
        run(100);

        repeat (3000) begin
            if ($urandom_range(0, 99) < 3) freq_i = 16'($urandom);
            if ($urandom_range(0, 99) < 2) mode_i = 2'($urandom_range(0, 3));
            if ($urandom_range(0, 99) < 5) duty_i = 8'($urandom);
            en_i   = ($urandom_range(0, 9) != 0);
            sync_i = ($urandom_range(0, 199) == 0);
            step();
        end
        sync_i = 1'b0;
        en_i   = 1'b1;
        freq_i = 16'h8000;
        mode_i = 2'(WAVE_SAW);
        run(37);

        do_reset(3);
        run(600);

        en_i = 1'b0;
        run(4);
        check("data_queue_drained", data_q.size(), 1);
        check("strobe_queue_drained", strobe_q.size(), 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
